// File: rtl/rv_mem_pkg.sv
// Shared memory-stage definitions: data/address widths, the store buffer
// entry layout and small address/lane helpers used by the store buffer.
package rv_mem_pkg;

  // Datapath widths for the memory stage; every store buffer instance is
  // built from these so that entry layout and ports always agree.
  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int BE_W    = XLEN / 8;
  localparam int OFS_W   = $clog2(BE_W);
  localparam int WADDR_W = ADDR_W - OFS_W;

  // One buffered store: word address, lane-aligned data and byte enables.
  typedef struct packed {
    logic               valid;
    logic [WADDR_W-1:0] waddr;
    logic [XLEN-1:0]    data;
    logic [BE_W-1:0]    be;
  } sb_entry_t;

  // Drop the byte offset so stores and loads compare on whole words.
  function automatic logic [WADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
    return WADDR_W'(addr >> OFS_W);
  endfunction

  // Overwrite the enabled byte lanes of oldData with newData.
  function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] oldData,
                                                 input logic [XLEN-1:0] newData,
                                                 input logic [BE_W-1:0] be);
    logic [XLEN-1:0] res;
    res = oldData;
    for (int l = 0; l < BE_W; l++) begin
      if (be[l]) res[8*l +: 8] = newData[8*l +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/store_buffer_fwd_lookup.sv
// Combinational store-to-load forwarding search. Walks the occupied entries
// from oldest (head) to youngest, so a later matching entry overrides an
// earlier one lane by lane: each lane ends up with the youngest store that
// wrote it.
module sb_fwd_lookup
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  sb_entry_t                      entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]       head,
  input  logic [$clog2(DEPTH):0]         count,
  input  logic                           ldValid,
  input  logic [WADDR_W-1:0]             ldWaddr,
  input  logic [BE_W-1:0]                ldBe,
  output logic [BE_W-1:0]                fwdMask,
  output logic [XLEN-1:0]                fwdData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] idx;
  logic [BE_W-1:0]  covered;
  logic [XLEN-1:0]  laneData;

  // Oldest-to-youngest scan: younger matches overwrite lanes already found.
  always_comb begin
    idx      = '0;
    covered  = '0;
    laneData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && entries[idx].valid &&
          (entries[idx].waddr == ldWaddr)) begin
        for (int l = 0; l < BE_W; l++) begin
          if (entries[idx].be[l]) begin
            covered[l]         = 1'b1;
            laneData[8*l +: 8] = entries[idx].data[8*l +: 8];
          end
        end
      end
    end
  end

  // Only lanes the load asked for are reported; everything else reads zero.
  always_comb begin
    fwdMask = ldValid ? (covered & ldBe) : '0;
    fwdData = '0;
    for (int l = 0; l < BE_W; l++) begin
      if (fwdMask[l]) fwdData[8*l +: 8] = laneData[8*l +: 8];
    end
  end

endmodule

// File: rtl/store_buffer_fwd.sv
// Store buffer with store-to-load forwarding for the MEM stage.
// Retiring stores are queued in a circular buffer and drained to data memory
// over a valid/ready port; loads see forwarded bytes from buffered stores and
// are stalled on a partial overlap until the overlapping stores have drained.
// Optional feature macro: SB_COALESCE_EN -- a store to the same word as the
// youngest (non-head) entry merges into it instead of allocating.
//
// Handshakes (both ports): a transfer happens on a rising edge where valid
// and ready are both 1; valid never depends on ready, and the presented
// fields are held stable while valid=1 and ready=0.
//
// Widths XLEN/ADDR_W are taken from rv_mem_pkg so the entry struct and the
// ports always match; DEPTH is the per-instance size.
module store_buffer_fwd
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [XLEN-1:0]            st_data,
  input  logic [BE_W-1:0]            st_be,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [BE_W-1:0]            ld_be,
  output logic                       ld_fwd_hit,
  output logic [BE_W-1:0]            ld_fwd_mask,
  output logic [XLEN-1:0]            ld_fwd_data,
  output logic                       ld_stall,
  output logic                       mem_wr_valid,
  input  logic                       mem_wr_ready,
  output logic [ADDR_W-1:0]          mem_wr_addr,
  output logic [XLEN-1:0]            mem_wr_data,
  output logic [BE_W-1:0]            mem_wr_be,
  output logic [$clog2(DEPTH):0]     sb_count,
  output logic                       sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t          entries [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  logic               full;
  logic               empty;
  logic               canMerge;
  logic               doPush;
  logic               doAlloc;
  logic               doMerge;
  logic               doDrain;
  logic [WADDR_W-1:0] stWaddr;
  logic [WADDR_W-1:0] ldWaddr;
  logic [BE_W-1:0]    fwdMask;
  logic [XLEN-1:0]    fwdData;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign stWaddr = word_addr(st_addr);
  assign ldWaddr = word_addr(ld_addr);

`ifdef SB_COALESCE_EN
  logic [PTR_W-1:0] youngest;

  // Merge target is the most recently allocated entry. It must not be the
  // head (count>=2 guarantees that), since the head may be mid-handshake.
  always_comb begin
    youngest = tail - PTR_W'(1);
    canMerge = (count >= CNT_W'(2)) && entries[youngest].valid &&
               (entries[youngest].waddr == stWaddr);
  end
`else
  assign canMerge = 1'b0;
`endif

  // A merge needs no free slot, so it is accepted even when full.
  assign st_ready = !full || canMerge;
  assign doPush   = st_valid && st_ready;
  assign doMerge  = doPush && canMerge;
  assign doAlloc  = doPush && !canMerge;
  assign doDrain  = !empty && mem_wr_ready;

  // Pointers, occupancy and entry storage; drain and enqueue may share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (doDrain) begin
        entries[head].valid <= 1'b0;
        head                <= head + PTR_W'(1);
      end
      if (doAlloc) begin
        entries[tail].valid <= 1'b1;
        entries[tail].waddr <= stWaddr;
        entries[tail].data  <= st_data;
        entries[tail].be    <= st_be;
        tail                <= tail + PTR_W'(1);
      end
`ifdef SB_COALESCE_EN
      if (doMerge) begin
        entries[youngest].data <= lane_merge(entries[youngest].data, st_data, st_be);
        entries[youngest].be   <= entries[youngest].be | st_be;
      end
`endif
      case ({doAlloc, doDrain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // doMerge only drives state when coalescing is built in.
  logic unusedMerge;
  assign unusedMerge = doMerge;

  // Memory write port is the head entry itself.
  always_comb begin
    mem_wr_valid = !empty;
    mem_wr_addr  = {entries[head].waddr, {OFS_W{1'b0}}};
    mem_wr_data  = entries[head].data;
    mem_wr_be    = entries[head].be;
    sb_count     = count;
    sb_empty     = empty;
  end

  sb_fwd_lookup #(
    .DEPTH (DEPTH)
  ) u_lookup (
    .entries (entries),
    .head    (head),
    .count   (count),
    .ldValid (ld_valid),
    .ldWaddr (ldWaddr),
    .ldBe    (ld_be),
    .fwdMask (fwdMask),
    .fwdData (fwdData)
  );

  // Full coverage is a forward; any partial coverage must wait for the drain.
  always_comb begin
    ld_fwd_mask = fwdMask;
    ld_fwd_data = fwdData;
    ld_fwd_hit  = ld_valid && (ld_be != '0) && (fwdMask == ld_be);
    ld_stall    = ld_valid && (fwdMask != '0) && !ld_fwd_hit;
  end

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Self-checking bench for store_buffer_fwd (DEPTH=4, XLEN=32).
// Inputs change 1ns after the rising edge, outputs are checked 3ns after it,
// and the drain monitor samples on the falling edge.
module tb_store_buffer_fwd;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_be;
  logic        ld_fwd_hit;
  logic [3:0]  ld_fwd_mask;
  logic [31:0] ld_fwd_data;
  logic        ld_stall;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic [2:0]  sb_count;
  logic        sb_empty;

  // expected buffer contents / write order: {word-aligned addr, data, be}
  logic [67:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  store_buffer_fwd #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_be        (st_be),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_be        (ld_be),
    .ld_fwd_hit   (ld_fwd_hit),
    .ld_fwd_mask  (ld_fwd_mask),
    .ld_fwd_data  (ld_fwd_data),
    .ld_stall     (ld_stall),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_be    (mem_wr_be),
    .sb_count     (sb_count),
    .sb_empty     (sb_empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic bit model_can_merge(input logic [31:0] a);
`ifdef SB_COALESCE_EN
    if (exp_q.size() >= 2 && exp_q[exp_q.size()-1][67:36] == (a & 32'hFFFF_FFFC)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit model_ready(input logic [31:0] a);
    return (exp_q.size() < 4) || model_can_merge(a);
  endfunction

  function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [67:0] e;
    if (model_can_merge(a)) begin
      e = exp_q[exp_q.size()-1];
      for (int l = 0; l < 4; l++) begin
        if (b[l]) e[4 + 8*l +: 8] = d[8*l +: 8];
      end
      e[3:0] = e[3:0] | b;
      exp_q[exp_q.size()-1] = e;
    end else begin
      exp_q.push_back({a & 32'hFFFF_FFFC, d, b});
    end
  endfunction

  // ---------------- scoreboard: memory writes ----------------
  always @(negedge clk) begin
    logic [67:0] e;
    if (rst_n && mem_wr_valid && mem_wr_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL drain_unexpected: got addr %h data %h be %b, expected no write",
                 mem_wr_addr, mem_wr_data, mem_wr_be);
      end else begin
        e = exp_q.pop_front();
        if ({mem_wr_addr, mem_wr_data, mem_wr_be} !== e)
          $display("FAIL drain_write: got %h/%h/%b expected %h/%h/%b",
                   mem_wr_addr, mem_wr_data, mem_wr_be, e[67:36], e[35:4], e[3:0]);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks (enter and leave at posedge+1) ----------------
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    bit done;
    bit er;
    done     = 1'b0;
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_be    = b;
    for (int k = 0; k < 20 && !done; k++) begin
      #2;
      er = model_ready(a);
      n_total++;
      if (st_ready !== er) $display("FAIL st_ready: got %b expected %b (addr %h)", st_ready, er, a);
      else n_pass++;
      n_total++;
      if (sb_count !== 3'(exp_q.size())) $display("FAIL sb_count: got %0d expected %0d", sb_count, exp_q.size());
      else n_pass++;
      if (er) begin
        model_store(a, d, b);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    st_valid = 1'b0;
    if (!done) begin
      n_total++;
      $display("FAIL store_timeout: got not accepted expected accepted (addr %h)", a);
    end
  endtask

  task automatic do_load(input string nm, input logic [31:0] a, input logic [3:0] b,
                         input logic [3:0] em, input logic [31:0] ed, input logic eh, input logic es);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_be    = b;
    #2;
    n_total++;
    if ({ld_fwd_mask, ld_fwd_data, ld_fwd_hit, ld_stall} !== {em, ed, eh, es})
      $display("FAIL %s: got mask %b data %h hit %b stall %b expected mask %b data %h hit %b stall %b",
               nm, ld_fwd_mask, ld_fwd_data, ld_fwd_hit, ld_stall, em, ed, eh, es);
    else n_pass++;
    ld_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain_all();
    bit done;
    done = 1'b0;
    mem_wr_ready = 1'b1;
    for (int k = 0; k < 30 && !done; k++) begin
      #2;
      if (sb_empty === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
    mem_wr_ready = 1'b0;
    n_total++;
    if (!done || exp_q.size() != 0)
      $display("FAIL drain_timeout: got empty %b pending %0d expected empty 1 pending 0", sb_empty, exp_q.size());
    else n_pass++;
  endtask

  task automatic check_idle(input string nm);
    #2;
    n_total++;
    if ({sb_empty, mem_wr_valid, st_ready, sb_count} !== {1'b1, 1'b0, 1'b1, 3'd0})
      $display("FAIL %s: got empty %b wr_valid %b st_ready %b count %0d expected 1 0 1 0",
               nm, sb_empty, mem_wr_valid, st_ready, sb_count);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("reset_state");
    do_store(32'h700, 32'h0102_0304, 4'b1111);
    do_store(32'h704, 32'h0506_0708, 4'b1111);
    #2;
    n_total++;
    if (sb_count !== 3'd2) $display("FAIL held_entries: got %0d expected 2", sb_count);
    else n_pass++;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_total++;
    if ({sb_empty, mem_wr_valid} !== 2'b10)
      $display("FAIL async_reset: got empty %b wr_valid %b expected 1 0", sb_empty, mem_wr_valid);
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle("reset_mid_drain");
    mem_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_wr_ready = 1'b0;
  endtask

  task automatic test_full_forward();
    do_store(32'h100, 32'hAABB_CCDD, 4'b1111);
    do_load("fwd_full", 32'h100, 4'b1111, 4'b1111, 32'hAABB_CCDD, 1'b1, 1'b0);
    do_load("fwd_byte", 32'h102, 4'b0100, 4'b0100, 32'h00BB_0000, 1'b1, 1'b0);
    do_load("fwd_miss", 32'h104, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b0);
    do_load("fwd_be_zero", 32'h100, 4'b0000, 4'b0000, 32'h0, 1'b0, 1'b0);
    ld_addr = 32'h100; ld_be = 4'b1111; ld_valid = 1'b0;
    #2;
    n_total++;
    if ({ld_fwd_mask, ld_fwd_data, ld_fwd_hit, ld_stall} !== 38'h0)
      $display("FAIL ld_idle: got mask %b data %h hit %b stall %b expected all 0",
               ld_fwd_mask, ld_fwd_data, ld_fwd_hit, ld_stall);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_partial_stall();
    do_store(32'h200, 32'h0000_1122, 4'b0011);
    do_load("partial_stall", 32'h200, 4'b1111, 4'b0011, 32'h0000_1122, 1'b0, 1'b1);
    drain_all();
    do_load("partial_drained", 32'h200, 4'b1111, 4'b0000, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_youngest_wins();
    do_store(32'h300, 32'h1111_1111, 4'b1111);
    do_store(32'h300, 32'h0000_0022, 4'b0001);
    do_load("youngest_lane", 32'h300, 4'b1111, 4'b1111, 32'h1111_1122, 1'b1, 1'b0);
    drain_all();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_store(32'h500 + 32'(4*i), $urandom, 4'($urandom_range(1, 15)));
    #2;
    n_total++;
    if ({st_ready, sb_count} !== {1'b0, 3'd4})
      $display("FAIL full: got st_ready %b count %0d expected 0 4", st_ready, sb_count);
    else n_pass++;
    @(posedge clk); #1;
    mem_wr_ready = 1'b1;
    do_store(32'h510, $urandom, 4'b1111);
    do_store(32'h514, $urandom, 4'b1111);
    #2;
    n_total++;
    if (sb_count !== 3'd3) $display("FAIL enq_drain_count: got %0d expected 3", sb_count);
    else n_pass++;
    @(posedge clk); #1;
    drain_all();
  endtask

  task automatic test_same_cycle();
    st_valid = 1'b1; st_addr = 32'h600; st_data = 32'hCAFE_F00D; st_be = 4'b1111;
    ld_valid = 1'b1; ld_addr = 32'h600; ld_be = 4'b1111;
    #2;
    n_total++;
    if ({ld_fwd_mask, ld_fwd_hit} !== 5'b0) $display("FAIL enq_invisible: got mask %b hit %b expected 0 0", ld_fwd_mask, ld_fwd_hit);
    else n_pass++;
    model_store(32'h600, 32'hCAFE_F00D, 4'b1111);
    @(posedge clk); #1;
    st_valid = 1'b0;
    mem_wr_ready = 1'b1;
    #2;
    n_total++;
    if ({ld_fwd_hit, ld_fwd_data} !== {1'b1, 32'hCAFE_F00D})
      $display("FAIL drain_visible: got hit %b data %h expected 1 cafef00d", ld_fwd_hit, ld_fwd_data);
    else n_pass++;
    @(posedge clk); #1;
    mem_wr_ready = 1'b0;
    #2;
    n_total++;
    if ({ld_fwd_hit, sb_empty} !== 2'b01) $display("FAIL after_drain: got hit %b empty %b expected 0 1", ld_fwd_hit, sb_empty);
    else n_pass++;
    ld_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_coalesce();
    logic [2:0] exp_cnt;
`ifdef SB_COALESCE_EN
    exp_cnt = 3'd2;
`else
    exp_cnt = 3'd3;
`endif
    do_store(32'h3F0, 32'h5555_5555, 4'b1111);
    do_store(32'h400, 32'h0000_00A1, 4'b0001);
    do_store(32'h400, 32'h0000_B200, 4'b0010);
    #2;
    n_total++;
    if (sb_count !== exp_cnt) $display("FAIL coalesce_count: got %0d expected %0d", sb_count, exp_cnt);
    else n_pass++;
    @(posedge clk); #1;
    do_load("coalesce_fwd", 32'h400, 4'b0011, 4'b0011, 32'h0000_B2A1, 1'b1, 1'b0);
    drain_all();
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_be = '0; mem_wr_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_full_forward();
    test_partial_stall();
    test_youngest_wins();
    test_back_to_back();
    test_same_cycle();
    test_coalesce();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
